// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single outstanding word
// fetches over a req/ack handshake, presents the fetched instruction to
// decode and the sign extender, and handles branch redirects and flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out32,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_off,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;

    logic        w_req;
    logic [31:0] w_pc;
    logic [31:0] w_pend_pc;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_valid;
    logic [31:0] w_flush_pc;
    logic [31:0] w_branch_pc;

    // Word offset scaled to bytes; the shift drops branch_off[31:30].
    assign w_flush_pc  = flush_pc & ~32'd3;
    assign w_branch_pc = r_instr_pc + (branch_off << 2);

    // Next-state and next-value logic for the fetch FSM and its datapath.
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_pend_pc  = r_pend_pc;
        w_instr    = r_instr;
        w_instr_pc = r_instr_pc;
        w_valid    = r_valid;
        case (r_state)
            IDLE: begin
                w_state = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (flush) begin
                        w_pc = w_flush_pc;
                    end else begin
                        w_instr    = imem_rdata;
                        w_instr_pc = r_pc;
                        w_pc       = r_pc + 32'd4;
                        w_valid    = 1'b1;
                        w_state    = VALID;
                    end
                end else if (flush) begin
                    // Bus transfer cannot be abandoned; remember where to restart.
                    w_pend_pc = w_flush_pc;
                    w_state   = DROP;
                end
            end
            DROP: begin
                if (flush) begin
                    w_pend_pc = w_flush_pc;
                end
                if (imem_ack) begin
                    w_pc    = flush ? w_flush_pc : r_pend_pc;
                    w_state = FETCH;
                end
            end
            VALID: begin
                if (flush) begin
                    w_valid = 1'b0;
                    w_pc    = w_flush_pc;
                    w_state = FETCH;
                end else if (!stall) begin
                    w_valid = 1'b0;
                    w_state = FETCH;
                    if (branch_taken) begin
                        w_pc = w_branch_pc;
                    end
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
        w_req = (w_state == FETCH) || (w_state == DROP);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req      <= 1'b0;
            r_pc       <= RESET_PC & ~32'd3;
            r_pend_pc  <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_req      <= w_req;
            r_pc       <= w_pc;
            r_pend_pc  <= w_pend_pc;
            r_instr    <= w_instr;
            r_instr_pc <= w_instr_pc;
            r_valid    <= w_valid;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr_out32 = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus with a scoreboard of
// expected {instruction, pc} pairs pushed when an ack is accepted and popped
// when instr_valid rises.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out32;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_off;
    logic        flush;
    logic [31:0] flush_pc;

    int          n_chk;
    int          n_fail;
    logic [63:0] sb_q[$];
    logic        prev_valid;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_out32  (instr_out32),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (act=running exp=done)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, and score new instructions.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_instr", instr_out32, 32'hxxxx_xxxx);
            end else begin
                e = sb_q.pop_front();
                chk("sb_instr", instr_out32, e[63:32]);
                chk("sb_pc", instr_pc, e[31:0]);
            end
        end
        prev_valid = instr_valid;
    endtask

    // Wait (bounded) for a request, hold ack low for 'waits' cycles checking the
    // address is stable, then ack with 'data'.
    task automatic serve(input int waits, input logic [31:0] data, input bit accept);
        logic [31:0] a;
        int          n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("serve_req", {31'd0, imem_req}, 32'd1);
        a = imem_addr;
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("addr_stable", imem_addr, a);
            chk("req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        if (accept) sb_q.push_back({data, a});
        tick();
        imem_ack   = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        prev_valid   = 1'b0;
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = '0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_off   = '0;
        flush        = 1'b0;
        flush_pc     = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_instr", instr_out32, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);

        // First fetch, ack on the 2nd FETCH cycle
        rst_n = 1'b1;
        tick();
        chk("f1_req", {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h100);
        serve(1, 32'hB400_0041, 1'b1);
        chk("f1_valid", {31'd0, instr_valid}, 32'd1);
        chk("f1_next_addr", imem_addr, 32'h104);
        chk("f1_req_low", {31'd0, imem_req}, 32'd0);
        tick();
        chk("f2_addr", imem_addr, 32'h104);

        // Backward branch held off by stall
        stall = 1'b1;
        serve(0, 32'h1111_2222, 1'b1);
        branch_taken = 1'b1;
        branch_off   = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr_out32, 32'h1111_2222);
            chk("stall_addr", imem_addr, 32'h108);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        chk("bbr_addr", imem_addr, 32'h0FC);
        chk("bbr_valid", {31'd0, instr_valid}, 32'd0);

        // Flush beats stall and branch in VALID
        stall = 1'b1;
        serve(0, 32'h3333_4444, 1'b1);
        branch_taken = 1'b1;
        flush        = 1'b1;
        flush_pc     = 32'h200;
        tick();
        flush        = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        chk("fprec_addr", imem_addr, 32'h200);
        chk("fprec_valid", {31'd0, instr_valid}, 32'd0);

        // Flush during pending request; last flush wins
        tick();
        flush    = 1'b1;
        flush_pc = 32'h4444;
        tick();
        flush_pc = 32'h3003;
        tick();
        flush = 1'b0;
        chk("drop_addr", imem_addr, 32'h200);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("drop_addr2", imem_addr, 32'h200);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        chk("drop_new_addr", imem_addr, 32'h3000);

        // Ack and flush together in FETCH
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        flush      = 1'b1;
        flush_pc   = 32'hFFFF_FFF8;
        tick();
        imem_ack = 1'b0;
        flush    = 1'b0;
        chk("ackfl_addr", imem_addr, 32'hFFFF_FFF8);
        chk("ackfl_valid", {31'd0, instr_valid}, 32'd0);

        // Forward branch with wrap
        serve(0, 32'h5555_6666, 1'b1);
        chk("fwd_seq_addr", imem_addr, 32'hFFFF_FFFC);
        branch_taken = 1'b1;
        branch_off   = 32'h0000_0003;
        tick();
        branch_taken = 1'b0;
        chk("fwd_addr", imem_addr, 32'h0000_0004);

        // Sequential wrap
        imem_ack = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        imem_ack = 1'b0;
        flush    = 1'b0;
        serve(1, 32'h7777_8888, 1'b1);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        chk("wrap_req", {31'd0, imem_req}, 32'd1);

        // Asynchronous reset mid-fetch; late ack ignored
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h9999_AAAA;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd1);
        tick();
        chk("late_ack_valid2", {31'd0, instr_valid}, 32'd0);

        // Zero-wait fetch after reset
        serve(0, 32'hCAFE_F00D, 1'b1);
        chk("zw_valid", {31'd0, instr_valid}, 32'd1);
        tick();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
